// File: rtl/sdram_protocol_monitor.sv
// Passive SDRAM/Wishbone protocol checker: tracks per-chip-select timing windows and bank
// state, and reports sticky flags, per-cycle pulses and a saturating violation-cycle count.
module sdram_protocol_monitor #(
    parameter int unsigned CS_W     = 2,
    parameter int unsigned T_RFC    = 7,
    parameter int unsigned T_RP     = 3,
    parameter int unsigned T_RCD    = 3,
    parameter int unsigned INIT_CYC = 10000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [CS_W-1:0]  sdr_cs_n,
    input  logic             sdr_ras_n,
    input  logic             sdr_cas_n,
    input  logic             sdr_we_n,
    input  logic [1:0]       sdr_ba,
    input  logic             sdr_a10,
    input  logic             sdr_init_done,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_ack_o,
    input  logic             viol_clr_i,
    output logic [7:0]       viol_o,
    output logic [7:0]       viol_pulse_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             mon_state_o
);

    localparam logic S_INIT = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam int unsigned V_RFC  = 0;
    localparam int unsigned V_RP   = 1;
    localparam int unsigned V_RCD  = 2;
    localparam int unsigned V_CLSD = 3;
    localparam int unsigned V_STB  = 4;
    localparam int unsigned V_ACK  = 5;
    localparam int unsigned V_INIT = 6;
    localparam int unsigned V_BANK = 7;

    localparam int unsigned T_MAX12 = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int unsigned T_MAX   = (T_MAX12 > T_RCD) ? T_MAX12 : T_RCD;
    localparam int unsigned TCW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TCW-1:0] RFC_LD = TCW'((T_RFC > 0) ? T_RFC - 1 : 0);
    localparam logic [TCW-1:0] RP_LD  = TCW'((T_RP > 0) ? T_RP - 1 : 0);
    localparam logic [TCW-1:0] RCD_LD = TCW'((T_RCD > 0) ? T_RCD - 1 : 0);

    localparam int unsigned    INIT_W   = (INIT_CYC > 0) ? $clog2(INIT_CYC + 1) : 1;
    localparam logic [INIT_W-1:0] INIT_SAT = INIT_W'(INIT_CYC);
    localparam logic [INIT_W:0]   INIT_LIM = (INIT_W + 1)'(INIT_CYC);

    // Shared command-line decode; the chip selects gate it per CS below.
    logic [2:0] cmd_bits;
    logic       op_nop, op_act, op_rd, op_wr, op_pre, op_ref, op_mrs;

    assign cmd_bits = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign op_nop   = (cmd_bits == 3'b111);
    assign op_act   = (cmd_bits == 3'b011);
    assign op_rd    = (cmd_bits == 3'b101);
    assign op_wr    = (cmd_bits == 3'b100);
    assign op_pre   = (cmd_bits == 3'b010);
    assign op_ref   = (cmd_bits == 3'b001);
    assign op_mrs   = (cmd_bits == 3'b000);

    logic [CS_W-1:0] cs_sel, cs_cmd, cs_act, cs_rw, cs_pre, cs_ref, cs_mrs;

    assign cs_sel = ~sdr_cs_n;
    assign cs_cmd = cs_sel & {CS_W{~op_nop}};
    assign cs_act = cs_sel & {CS_W{op_act}};
    assign cs_rw  = cs_sel & {CS_W{op_rd | op_wr}};
    assign cs_pre = cs_sel & {CS_W{op_pre}};
    assign cs_ref = cs_sel & {CS_W{op_ref}};
    assign cs_mrs = cs_sel & {CS_W{op_mrs}};

    logic [TCW-1:0]    rfc_q [CS_W];
    logic [TCW-1:0]    rfc_d [CS_W];
    logic [TCW-1:0]    rp_q  [CS_W];
    logic [TCW-1:0]    rp_d  [CS_W];
    logic [TCW-1:0]    rcd_q [CS_W][4];
    logic [TCW-1:0]    rcd_d [CS_W][4];
    logic [3:0]        open_q [CS_W];
    logic [3:0]        open_d [CS_W];

    logic              state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [INIT_W:0]   init_elapsed;
    logic [7:0]        new_viol;
    logic [7:0]        viol_q, viol_d;
    logic [7:0]        pulse_q;
    logic [CNT_W-1:0]  err_q, err_d;

    function automatic logic [TCW-1:0] tick_down(input logic [TCW-1:0] v);
        return (v == '0) ? '0 : v - TCW'(1);
    endfunction

    // The current edge counts as an elapsed clock, so the first edge after release is 1.
    assign init_elapsed = {1'b0, init_cnt_q} + (INIT_W + 1)'(1);

    always_comb begin
        new_viol   = '0;
        state_d    = state_q;
        init_cnt_d = init_cnt_q;

        for (int c = 0; c < CS_W; c++) begin
            rfc_d[c] = cs_ref[c] ? RFC_LD : tick_down(rfc_q[c]);
            if (cs_cmd[c] && (rfc_q[c] != '0)) new_viol[V_RFC] = 1'b1;

            rp_d[c] = cs_pre[c] ? RP_LD : tick_down(rp_q[c]);
            if ((cs_act[c] || cs_ref[c]) && (rp_q[c] != '0)) new_viol[V_RP] = 1'b1;

            for (int b = 0; b < 4; b++) begin
                rcd_d[c][b] = (cs_act[c] && (sdr_ba == 2'(b))) ? RCD_LD
                                                              : tick_down(rcd_q[c][b]);
            end
            if (cs_rw[c] && (rcd_q[c][sdr_ba] != '0)) new_viol[V_RCD] = 1'b1;

            if (cs_rw[c] && !open_q[c][sdr_ba]) new_viol[V_CLSD] = 1'b1;
            if (cs_act[c] && open_q[c][sdr_ba]) new_viol[V_BANK] = 1'b1;
            if (cs_ref[c] && (open_q[c] != 4'b0000)) new_viol[V_BANK] = 1'b1;

            open_d[c] = open_q[c];
            if (cs_act[c]) begin
                open_d[c][sdr_ba] = 1'b1;
            end else if (cs_pre[c]) begin
                if (sdr_a10) open_d[c] = 4'b0000;
                else         open_d[c][sdr_ba] = 1'b0;
            end

            if ((state_q == S_INIT) && cs_cmd[c] && !(cs_pre[c] || cs_ref[c] || cs_mrs[c])) begin
                new_viol[V_INIT] = 1'b1;
            end
        end

        if (wb_stb_i && !wb_cyc_i) new_viol[V_STB] = 1'b1;
        if (wb_ack_o && !(wb_cyc_i && wb_stb_i)) new_viol[V_ACK] = 1'b1;

        if (state_q == S_INIT) begin
            if (sdr_init_done) begin
                state_d = S_RUN;
                if (init_elapsed < INIT_LIM) new_viol[V_INIT] = 1'b1;
            end else if (init_cnt_q != INIT_SAT) begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
            end
        end else if (!sdr_init_done) begin
            state_d    = S_INIT;
            init_cnt_d = '0;
        end
    end

    // A violation landing in the clear cycle survives the clear.
    always_comb begin
        viol_d = viol_clr_i ? new_viol : (viol_q | new_viol);
        err_d  = err_q;
        if (viol_clr_i) begin
            err_d = (new_viol != 8'h00) ? CNT_W'(1) : '0;
        end else if ((new_viol != 8'h00) && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int c = 0; c < CS_W; c++) begin
                rfc_q[c]  <= '0;
                rp_q[c]   <= '0;
                open_q[c] <= 4'b0000;
                for (int b = 0; b < 4; b++) rcd_q[c][b] <= '0;
            end
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            viol_q     <= '0;
            pulse_q    <= '0;
            err_q      <= '0;
        end else begin
            for (int c = 0; c < CS_W; c++) begin
                rfc_q[c]  <= rfc_d[c];
                rp_q[c]   <= rp_d[c];
                open_q[c] <= open_d[c];
                for (int b = 0; b < 4; b++) rcd_q[c][b] <= rcd_d[c][b];
            end
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            viol_q     <= viol_d;
            pulse_q    <= new_viol;
            err_q      <= err_d;
        end
    end

    assign viol_o       = viol_q;
    assign viol_pulse_o = pulse_q;
    assign err_cnt_o    = err_q;
    assign mon_state_o  = state_q;

endmodule

// File: tb/tb_sdram_protocol_monitor.sv
// Directed bench for sdram_protocol_monitor with a timestamp-based reference model
// checked against the DUT outputs every cycle.
module tb_sdram_protocol_monitor;

    localparam int unsigned CS_W     = 2;
    localparam int unsigned T_RFC    = 7;
    localparam int unsigned T_RP     = 3;
    localparam int unsigned T_RCD    = 3;
    localparam int unsigned INIT_CYC = 10000;
    localparam int unsigned CNT_W    = 4;
    localparam int          ERR_MAX  = (1 << CNT_W) - 1;

    localparam logic [2:0] OP_NOP = 3'b111;
    localparam logic [2:0] OP_ACT = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_REF = 3'b001;

    logic             clk = 1'b0;
    logic             rst;
    logic [CS_W-1:0]  cs_n;
    logic             ras_n, cas_n, we_n;
    logic [1:0]       ba;
    logic             a10;
    logic             init_done;
    logic             cyc, stb, ack;
    logic             clr;
    logic [7:0]       viol, pulse;
    logic [CNT_W-1:0] err;
    logic             mstate;

    sdram_protocol_monitor #(
        .CS_W(CS_W), .T_RFC(T_RFC), .T_RP(T_RP), .T_RCD(T_RCD),
        .INIT_CYC(INIT_CYC), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .sdr_cs_n     (cs_n),
        .sdr_ras_n    (ras_n),
        .sdr_cas_n    (cas_n),
        .sdr_we_n     (we_n),
        .sdr_ba       (ba),
        .sdr_a10      (a10),
        .sdr_init_done(init_done),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_ack_o     (ack),
        .viol_clr_i   (clr),
        .viol_o       (viol),
        .viol_pulse_o (pulse),
        .err_cnt_o    (err),
        .mon_state_o  (mstate)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last-command timestamps instead of down-counters.
    longint cyc_m = 0;
    longint rel_m = 0;
    longint t_ref [CS_W];
    longint t_pre [CS_W];
    longint t_act [CS_W][4];
    bit     open_m [CS_W][4];
    bit     st_m = 1'b0;
    bit     valid = 1'b0;
    logic [7:0] e_viol = '0;
    logic [7:0] e_pulse = '0;
    int         e_err = 0;

    function automatic logic [7:0] model_viol();
        logic [7:0] v;
        logic [2:0] op;
        bit         any_open;
        v  = '0;
        op = {ras_n, cas_n, we_n};
        for (int c = 0; c < CS_W; c++) begin
            if (cs_n[c] == 1'b0 && op != OP_NOP) begin
                any_open = 1'b0;
                for (int b = 0; b < 4; b++) any_open |= open_m[c][b];
                if (cyc_m - t_ref[c] < T_RFC) v[0] = 1'b1;
                if ((op == OP_ACT || op == OP_REF) && cyc_m - t_pre[c] < T_RP) v[1] = 1'b1;
                if (op == OP_RD || op == 3'b100) begin
                    if (cyc_m - t_act[c][ba] < T_RCD) v[2] = 1'b1;
                    if (!open_m[c][ba]) v[3] = 1'b1;
                end
                if (op == OP_ACT && open_m[c][ba]) v[7] = 1'b1;
                if (op == OP_REF && any_open) v[7] = 1'b1;
                if (!st_m && !(op == OP_PRE || op == OP_REF || op == 3'b000)) v[6] = 1'b1;
            end
        end
        if (stb && !cyc) v[4] = 1'b1;
        if (ack && !(cyc && stb)) v[5] = 1'b1;
        if (!st_m && init_done && (cyc_m - rel_m) < INIT_CYC) v[6] = 1'b1;
        return v;
    endfunction

    function automatic int next_err(input logic [7:0] nv);
        if (clr) return (nv != 8'h00) ? 1 : 0;
        if (nv != 8'h00 && e_err < ERR_MAX) return e_err + 1;
        return e_err;
    endfunction

    always @(posedge clk) begin
        cyc_m <= cyc_m + 1;
        if (rst) begin
            for (int c = 0; c < CS_W; c++) begin
                t_ref[c] <= -100;
                t_pre[c] <= -100;
                for (int b = 0; b < 4; b++) begin
                    t_act[c][b]  <= -100;
                    open_m[c][b] <= 1'b0;
                end
            end
            st_m    <= 1'b0;
            rel_m   <= cyc_m;
            e_viol  <= '0;
            e_pulse <= '0;
            e_err   <= 0;
            valid   <= 1'b1;
        end else begin
            e_pulse <= model_viol();
            e_viol  <= clr ? model_viol() : (e_viol | model_viol());
            e_err   <= next_err(model_viol());
            for (int c = 0; c < CS_W; c++) begin
                if (cs_n[c] == 1'b0) begin
                    if ({ras_n, cas_n, we_n} == OP_REF) t_ref[c] <= cyc_m;
                    if ({ras_n, cas_n, we_n} == OP_PRE) begin
                        t_pre[c] <= cyc_m;
                        for (int b = 0; b < 4; b++) begin
                            if (a10 || ba == 2'(b)) open_m[c][b] <= 1'b0;
                        end
                    end
                    if ({ras_n, cas_n, we_n} == OP_ACT) begin
                        t_act[c][ba]  <= cyc_m;
                        open_m[c][ba] <= 1'b1;
                    end
                end
            end
            if (!st_m && init_done) begin
                st_m <= 1'b1;
            end else if (st_m && !init_done) begin
                st_m  <= 1'b0;
                rel_m <= cyc_m;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("viol_o", 32'(viol), 32'(e_viol));
            chk("viol_pulse_o", 32'(pulse), 32'(e_pulse));
            chk("err_cnt_o", 32'(err), 32'(e_err));
            chk("mon_state_o", 32'(mstate), 32'(st_m));
        end
    end

    // Literal expectation pinned against both the DUT and the model.
    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] mdl,
                       input logic [31:0] exp);
        chk({nm, "_dut"}, got, exp);
        chk({nm, "_model"}, mdl, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic [CS_W-1:0] cs, input logic [2:0] op, input logic [1:0] b,
                       input logic a);
        cs_n = cs;
        {ras_n, cas_n, we_n} = op;
        ba  = b;
        a10 = a;
        step(1);
        cs_n = '1;
        {ras_n, cas_n, we_n} = OP_NOP;
        ba  = 2'd0;
        a10 = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cs_n = '1;
        {ras_n, cas_n, we_n} = OP_NOP;
        ba = 2'd0; a10 = 1'b0; init_done = 1'b0;
        cyc = 1'b0; stb = 1'b0; ack = 1'b0; clr = 1'b0;
        step(2);
        lit("reset_viol", 32'(viol), 32'(e_viol), 32'h0);
        lit("reset_err", 32'(err), 32'(e_err), 32'h0);
        lit("reset_state", 32'(mstate), 32'(st_m), 32'h0);
        rst = 1'b0;

        // Read during init: V6 plus closed-bank V3, counted once.
        step(10);
        cmd(2'b10, OP_RD, 2'd0, 1'b0);
        lit("init_read_pulse", 32'(pulse), 32'(e_pulse), 32'h48);
        lit("init_read_err", 32'(err), 32'(e_err), 32'h1);
        step(488);
        init_done = 1'b1;
        step(1);
        lit("early_done_viol", 32'(viol), 32'(e_viol), 32'h48);
        lit("early_done_pulse", 32'(pulse), 32'(e_pulse), 32'h40);
        lit("early_done_err", 32'(err), 32'(e_err), 32'h2);
        lit("early_done_state", 32'(mstate), 32'(st_m), 32'h1);
        do_clear();
        lit("clear_viol", 32'(viol), 32'(e_viol), 32'h0);
        lit("clear_err", 32'(err), 32'(e_err), 32'h0);

        // Drop init_done, then rise exactly INIT_CYC clocks later.
        init_done = 1'b0;
        step(1);
        lit("reinit_state", 32'(mstate), 32'(st_m), 32'h0);
        step(INIT_CYC - 1);
        init_done = 1'b1;
        step(1);
        lit("full_init_state", 32'(mstate), 32'(st_m), 32'h1);
        lit("full_init_viol", 32'(viol), 32'(e_viol), 32'h0);

        // tRFC: second REF 4 clocks later flags, 7 later does not, 6 later does.
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        step(3);
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        lit("rfc_pulse", 32'(pulse), 32'(e_pulse), 32'h01);
        lit("rfc_err", 32'(err), 32'(e_err), 32'h1);
        step(1);
        lit("rfc_pulse_drop", 32'(pulse), 32'(e_pulse), 32'h00);
        lit("rfc_sticky", 32'(viol), 32'(e_viol), 32'h01);
        step(8);
        do_clear();
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        step(6);
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        lit("rfc_ok_viol", 32'(viol), 32'(e_viol), 32'h00);
        step(5);
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        lit("rfc_edge_pulse", 32'(pulse), 32'(e_pulse), 32'h01);
        step(8);
        do_clear();

        // tRCD and bank state on CS1, then both CS in one cycle.
        cmd(2'b01, OP_ACT, 2'd2, 1'b0);
        cmd(2'b01, OP_RD, 2'd2, 1'b0);
        lit("rcd_pulse", 32'(pulse), 32'(e_pulse), 32'h04);
        lit("rcd_err", 32'(err), 32'(e_err), 32'h1);
        cmd(2'b01, OP_RD, 2'd1, 1'b0);
        lit("closed_pulse", 32'(pulse), 32'(e_pulse), 32'h08);
        lit("closed_viol", 32'(viol), 32'(e_viol), 32'h0C);
        cmd(2'b01, OP_ACT, 2'd3, 1'b0);
        cmd(2'b00, OP_RD, 2'd3, 1'b0);
        lit("dual_cs_pulse", 32'(pulse), 32'(e_pulse), 32'h0C);
        lit("dual_cs_err", 32'(err), 32'(e_err), 32'h3);
        cmd(2'b01, OP_ACT, 2'd2, 1'b0);
        lit("act_open_pulse", 32'(pulse), 32'(e_pulse), 32'h80);

        // tRP: PRE-all on both, then ACT and REF inside the window.
        cmd(2'b00, OP_PRE, 2'd0, 1'b1);
        cmd(2'b01, OP_ACT, 2'd0, 1'b0);
        lit("rp_act_pulse", 32'(pulse), 32'(e_pulse), 32'h02);
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        lit("rp_ref_pulse", 32'(pulse), 32'(e_pulse), 32'h02);
        lit("rp_viol", 32'(viol), 32'(e_viol), 32'h8E);
        lit("rp_err", 32'(err), 32'(e_err), 32'h6);
        step(8);
        cmd(2'b01, OP_REF, 2'd0, 1'b0);
        lit("ref_open_pulse", 32'(pulse), 32'(e_pulse), 32'h80);
        step(8);
        cmd(2'b01, OP_PRE, 2'd0, 1'b1);
        do_clear();

        // Wishbone checks.
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        lit("stb_pulse", 32'(pulse), 32'(e_pulse), 32'h10);
        step(1);
        lit("stb_pulse_drop", 32'(pulse), 32'(e_pulse), 32'h00);
        lit("stb_sticky", 32'(viol), 32'(e_viol), 32'h10);
        ack = 1'b1;
        step(1);
        lit("ack_pulse", 32'(pulse), 32'(e_pulse), 32'h20);
        cyc = 1'b1; stb = 1'b1;
        step(1);
        lit("ack_ok_pulse", 32'(pulse), 32'(e_pulse), 32'h00);
        cyc = 1'b0; stb = 1'b0; ack = 1'b0;

        // Clear and violation in the same cycle, then counter saturation.
        clr = 1'b1; stb = 1'b1;
        step(1);
        clr = 1'b0; stb = 1'b0;
        lit("clr_win_viol", 32'(viol), 32'(e_viol), 32'h10);
        lit("clr_win_err", 32'(err), 32'(e_err), 32'h1);
        stb = 1'b1;
        step(20);
        stb = 1'b0;
        lit("err_saturate", 32'(err), 32'(e_err), 32'(ERR_MAX));
        do_clear();

        // Reset in the middle of a tRFC window.
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        rst = 1'b1; init_done = 1'b0;
        step(1);
        lit("rst_viol", 32'(viol), 32'(e_viol), 32'h0);
        lit("rst_pulse", 32'(pulse), 32'(e_pulse), 32'h0);
        lit("rst_err", 32'(err), 32'(e_err), 32'h0);
        lit("rst_state", 32'(mstate), 32'(st_m), 32'h0);
        rst = 1'b0;
        cmd(2'b10, OP_REF, 2'd0, 1'b0);
        lit("post_rst_ref_pulse", 32'(pulse), 32'(e_pulse), 32'h0);
        lit("post_rst_ref_viol", 32'(viol), 32'(e_viol), 32'h0);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
